pipe_stage: RTL

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 56 +++++
 rtl/pipe_stage.sv | 78 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage: default payload widths, the payload
// struct and an occupancy helper used by both the single-entry and skid builds.
package pipe_pkg;

    localparam int CTRL_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] alu;
        logic [DATA_W_DEF-1:0] wdata;
        logic [REG_W_DEF-1:0]  wreg;
    } payload_t;

    function automatic logic [1:0] occupancy(input logic head_vld, input logic skid_vld);
        return {1'b0, head_vld} + {1'b0, skid_vld};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage: the head entry drives the stage outputs, the skid entry
// catches the one beat accepted while the output is blocked.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         head_vld,
    output logic [1:0]   count
);

    logic [W-1:0] head_p0;
    logic [W-1:0] skid_p1;
    logic         vld_p0;
    logic         vld_p1;

    // Occupancy bits: the skid entry is only ever valid while the head is valid.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (pop) begin
            if (vld_p1) vld_p1 <= push;
            else        vld_p0 <= push;
        end else if (push) begin
            if (vld_p0) vld_p1 <= 1'b1;
            else        vld_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            if (vld_p1) begin
                head_p0 <= skid_p1;
                if (push) skid_p1 <= din;
            end else if (push) begin
                head_p0 <= din;
            end
        end else if (push) begin
            if (vld_p0) skid_p1 <= din;
            else        head_p0 <= din;
        end
    end

    assign dout     = head_p0;
    assign head_vld = vld_p0;
    assign count    = occupancy(vld_p0, vld_p1);

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register stage with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered ready_out.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_W-1:0]  wreg_in,
    input  logic              stall,
    input  logic              flush,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic [REG_W-1:0]  wreg_out,
    output logic [1:0]        count
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + REG_W;

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_p0;
    logic             vld_p0;
    logic             in_fire;
    logic             out_fire;
    logic [1:0]       occ;

    assign pay_in   = {ctrl_in, alu_in, wdata_in, wreg_in};
    assign in_fire  = valid_in && ready_out;
    assign out_fire = vld_p0 && ready_in && !stall;

`ifdef PIPE_STAGE_SKID_EN
    // ready_out depends only on stored occupancy, so ready_in never reaches it.
    assign ready_out = (occ != 2'd2);

    pipe_skid_buf #(.W(PAY_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (in_fire),
        .pop      (out_fire),
        .din      (pay_in),
        .dout     (pay_p0),
        .head_vld (vld_p0),
        .count    (occ)
    );
`else
    assign ready_out = !vld_p0 || (ready_in && !stall);

    always_ff @(posedge clk) begin
        if (!rst_n || flush)  vld_p0 <= 1'b0;
        else if (in_fire)     vld_p0 <= 1'b1;
        else if (out_fire)    vld_p0 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_fire) pay_p0 <= pay_in;
    end

    assign occ = occupancy(vld_p0, 1'b0);
`endif

    // Payload is masked to zero whenever the stage holds a bubble.
    assign {ctrl_out, alu_out, wdata_out, wreg_out} = vld_p0 ? pay_p0 : '0;
    assign valid_out = vld_p0;
    assign count     = occ;

endmodule
